// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: raw columns in, row drive and latched key code out.
interface keypad_scan_if;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_r;
   logic [3:0] key_c;
   logic       startSet;

   modport master (input col_in, output row_out, key_r, key_c, startSet);
   modport slave  (output col_in, input row_out, key_r, key_c, startSet);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with press/release debounce; strobe rises (DEBOUNCE_CNT-1)*SCAN_DIV+2
// cycles after capture. No backpressure: the decoder must sample key_r/key_c on the startSet edge.
module keypad_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int STROBE_LEN   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   keypad_scan_if.master kp
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam int SW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

   typedef enum logic [2:0] {SCAN, DEBOUNCE, SETUP, STROBE, RELEASE} state_t;

   state_t        state;
   logic [3:0]    sync1, col_s;
   logic [DW-1:0] div;
   logic          tick;
   logic          valid;
   logic [3:0]    row_q, cand_r, cand_c, key_r_q, key_c_q;
   logic [CW-1:0] cnt, rcnt;
   logic [SW-1:0] scnt;
   logic          strobe_q;

   assign tick  = (div == DW'(SCAN_DIV - 1));
   // A valid press is exactly one column pulled low.
   assign valid = $onehot(~col_s);

   assign kp.row_out  = row_q;
   assign kp.key_r    = key_r_q;
   assign kp.key_c    = key_c_q;
   assign kp.startSet = strobe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 4'hF;
         col_s <= 4'hF;
      end else begin
         sync1 <= kp.col_in;
         col_s <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div <= '0;
      else if (tick)
         div <= '0;
      else
         div <= div + DW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SCAN;
         row_q    <= 4'b1110;
         cand_r   <= 4'hF;
         cand_c   <= 4'hF;
         key_r_q  <= 4'hF;
         key_c_q  <= 4'hF;
         cnt      <= '0;
         rcnt     <= '0;
         scnt     <= '0;
         strobe_q <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               if (tick) begin
                  if (valid) begin
                     cand_r <= row_q;
                     cand_c <= col_s;
                     cnt    <= CW'(1);
                     state  <= DEBOUNCE;
                  end else begin
                     row_q <= {row_q[2:0], row_q[3]};
                  end
               end
            end
            DEBOUNCE: begin
               if (cnt == CW'(DEBOUNCE_CNT)) begin
                  key_r_q <= cand_r;
                  key_c_q <= cand_c;
                  cnt     <= '0;
                  state   <= SETUP;
               end else if (tick) begin
                  if (col_s == cand_c) begin
                     cnt <= cnt + CW'(1);
                  end else begin
                     cnt   <= '0;
                     row_q <= {row_q[2:0], row_q[3]};
                     state <= SCAN;
                  end
               end
            end
            // Codes already settled; the strobe edge comes one cycle later.
            SETUP: begin
               strobe_q <= 1'b1;
               scnt     <= '0;
               state    <= STROBE;
            end
            STROBE: begin
               if (scnt == SW'(STROBE_LEN - 1)) begin
                  strobe_q <= 1'b0;
                  rcnt     <= '0;
                  state    <= RELEASE;
               end else begin
                  scnt <= scnt + SW'(1);
               end
            end
            RELEASE: begin
               if (tick) begin
                  if (col_s == 4'hF) begin
                     if (rcnt == CW'(DEBOUNCE_CNT - 1)) begin
                        rcnt  <= '0;
                        row_q <= {row_q[2:0], row_q[3]};
                        state <= SCAN;
                     end else begin
                        rcnt <= rcnt + CW'(1);
                     end
                  end else begin
                     rcnt <= '0;
                  end
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3, STROBE_LEN=2.
module tb_keypad_scan;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   keypad_scan_if kp ();

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .STROBE_LEN(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] r;
      logic [3:0] c;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         failures = 0;
   int         nstrobe = 0;
   int         k = 0;
   int         mode = 0;
   logic [3:0] pr_row = 4'hF, pr_col = 4'hF, force_col = 4'hF;
   logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Edge count since reset release; the divider ticks on edges where k%4==0.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) k <= 0;
      else        k <= k + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [3:0] rot(logic [3:0] r);
      return {r[2:0], r[3]};
   endfunction

   initial begin
      kp.col_in = 4'hF;
      forever begin
         @(negedge clk);
         case (mode)
            0:       kp.col_in = 4'hF;
            1:       kp.col_in = (kp.row_out == pr_row) ? pr_col : 4'hF;
            default: kp.col_in = force_col;
         endcase
      end
   end

   // Monitor: checks every strobe against the expectation queue.
   initial begin
      logic       prev_s;
      logic [3:0] pk_r, pk_c;
      int         width;
      exp_t       e;
      prev_s = 1'b0; width = 0; pk_r = 4'hF; pk_c = 4'hF;
      e = '{4'hF, 4'hF};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_s = 1'b0;
            width  = 0;
         end else begin
            if (kp.startSet && !prev_s) begin
               nstrobe++;
               width = 1;
               if (q.size() == 0) begin
                  chk("unexpected_strobe", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("key_r", kp.key_r, e.r);
                  chk("key_c", kp.key_c, e.c);
                  chk("key_r_setup", pk_r, e.r);
                  chk("key_c_setup", pk_c, e.c);
                  chk("rise_phase", k % 4, 2);
                  chk("row_frozen", kp.row_out, e.r);
               end
            end else if (kp.startSet) begin
               width++;
               chk("key_hold", {kp.key_r, kp.key_c}, {e.r, e.c});
            end
            if (!kp.startSet && prev_s)
               chk("strobe_width", width, 2);
            prev_s = kp.startSet;
         end
         pk_r = kp.key_r;
         pk_c = kp.key_c;
      end
   end

   task automatic wait_strobe(string nm, int n0);
      int c;
      c = 0;
      while (nstrobe == n0 && c < 150) begin
         @(negedge clk);
         c++;
      end
      chk({nm, "_seen"}, (nstrobe > n0), 1);
   endtask

   task automatic check_rot(string nm, int nsteps);
      logic [3:0] prev;
      int c;
      c = 0;
      while (k % 4 != 0 && c < 8) begin
         @(negedge clk);
         c++;
      end
      prev = kp.row_out;
      for (int i = 0; i < nsteps; i++) begin
         repeat (4) @(negedge clk);
         chk(nm, kp.row_out, rot(prev));
         prev = kp.row_out;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      repeat (3) @(negedge clk);
      chk("rst_row", kp.row_out, 4'b1110);
      chk("rst_keys", {kp.key_r, kp.key_c}, 8'hFF);
      chk("rst_strobe", kp.startSet, 0);
      rst_n = 1'b1;

      // Idle rotation against the independent divider model.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("idle_row", kp.row_out, rows[(k / 4) % 4]);
      end
      chk("idle_keys", {kp.key_r, kp.key_c}, 8'hFF);
      chk("idle_nstrobe", nstrobe, 0);

      // Key "5".
      q.push_back('{4'b1101, 4'b1101});
      pr_row = 4'b1101; pr_col = 4'b1101; mode = 1;
      repeat (60) @(negedge clk);
      mode = 0;
      repeat (20) @(negedge clk);
      chk("key5_nstrobe", nstrobe, 1);

      // Bounce on alternate ticks.
      mode = 2;
      for (int i = 0; i < 10; i++) begin
         force_col = (i % 2 == 0) ? 4'b1101 : 4'b1111;
         repeat (4) @(negedge clk);
      end
      mode = 0;
      chk("bounce_nstrobe", nstrobe, 1);
      check_rot("bounce_rot", 5);

      // Multi-key on row 1110 is not a key.
      pr_row = 4'b1110; pr_col = 4'b1100; mode = 1;
      check_rot("multi_rot", 8);
      mode = 0;
      chk("multi_nstrobe", nstrobe, 1);

      // Long press of "enter", then a fresh press.
      q.push_back('{4'b0111, 4'b1110});
      pr_row = 4'b0111; pr_col = 4'b1110; mode = 1;
      repeat (200) @(negedge clk);
      chk("long_nstrobe", nstrobe, 2);
      mode = 0;
      repeat (16) @(negedge clk);
      q.push_back('{4'b0111, 4'b1110});
      n0 = nstrobe;
      mode = 1;
      wait_strobe("enter2", n0);
      mode = 0;
      repeat (20) @(negedge clk);
      chk("enter2_nstrobe", nstrobe, 3);

      // Reset during the strobe.
      q.push_back('{4'b1011, 4'b0111});
      pr_row = 4'b1011; pr_col = 4'b0111; mode = 1;
      n0 = nstrobe;
      wait_strobe("rststrobe", n0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_strobe", kp.startSet, 0);
      chk("mid_rst_row", kp.row_out, 4'b1110);
      chk("mid_rst_keys", {kp.key_r, kp.key_c}, 8'hFF);
      mode = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("restart_row", kp.row_out, 4'b1101);
      check_rot("restart_rot", 4);

      chk("queue_empty", q.size(), 0);
      chk("total_nstrobe", nstrobe, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
